// File: rtl/prog_loader_if.sv
// -----------------------------------------------------------------------------
// prog_loader_if
//   Bundles the host-side byte stream and the core-side programming bus of the
//   program loader into one interface.
//
//   Host / byte stream:
//     load_start  request to begin a load (single-cycle pulse)
//     rx_data     incoming byte
//     rx_valid    rx_data valid
//     rx_ready    loader accepts a byte this cycle
//   Core programming bus:
//     ProgMode    0 = program mode, 1 = run mode
//     Addr_Prog   instruction-memory write address (ADDR_W bits)
//     Data_Prog   instruction word to write
//     Prog_We     one-cycle write strobe
//     cpu_reset   core reset
//   Status:
//     busy, done, err
//
//   Modports:
//     master  host/core side (drives the byte stream, observes the loader)
//     slave   the loader itself
// -----------------------------------------------------------------------------
interface prog_loader_if #(
  parameter int ADDR_W = 8
);
  logic              load_start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              ProgMode;
  logic [ADDR_W-1:0] Addr_Prog;
  logic [31:0]       Data_Prog;
  logic              Prog_We;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output load_start,
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  ProgMode,
    input  Addr_Prog,
    input  Data_Prog,
    input  Prog_We,
    input  cpu_reset,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  load_start,
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output ProgMode,
    output Addr_Prog,
    output Data_Prog,
    output Prog_We,
    output cpu_reset,
    output busy,
    output done,
    output err
  );
endinterface

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//   Programs the MIPS instruction memory from a byte stream, then releases the
//   core into run mode through a timed reset pulse.
//
//   Stream format: one count byte N (0 means 256 words), followed by N
//   big-endian 32-bit words. Each word is written to Addr_Prog with a single
//   cycle Prog_We strobe; the address starts at 0 and wraps modulo 2^ADDR_W.
//
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-high; returns to IDLE
//     bus    prog_loader_if.slave (byte stream in, programming bus and status out)
//
//   Parameters:
//     ADDR_W      instruction-memory address width
//     RST_CYCLES  cycles cpu_reset is held high after loading (>= 1)
//
//   Optional feature (macro PROG_LOADER_CHKSUM_EN):
//     When defined, a running XOR of all data bytes is kept and one checksum
//     byte follows the last word. A match releases the core; a mismatch parks
//     the loader in ERR with the core held in program mode and reset.
//     When undefined there is no checksum state and err is tied low.
//
//   All outputs are flops loaded with the decode of the next state, so each
//   output reflects the current state without any combinational path.
// -----------------------------------------------------------------------------
module prog_loader #(
  parameter int ADDR_W     = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  prog_loader_if.slave bus
);

  localparam int              RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_CNT  = 3'd1,
    S_GET_BYTE = 3'd2,
    S_WRITE    = 3'd3,
    S_RST_CPU  = 3'd4,
    S_RUN      = 3'd5
`ifdef PROG_LOADER_CHKSUM_EN
    ,
    S_CHK      = 3'd6,
    S_ERR      = 3'd7
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        cnt_q, cnt_d;        // words still to write, 1..256
  logic [1:0]        idx_q, idx_d;        // byte position within the word
  logic [23:0]       shift_q, shift_d;    // first three bytes of the word
  logic [31:0]       data_q, data_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;      // cycles spent in RST_CPU
  logic              we_q, we_d;
  logic              rx_ready_q, rx_ready_d;
  logic              prog_mode_q, prog_mode_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef PROG_LOADER_CHKSUM_EN
  logic [7:0]        chk_q, chk_d;
  logic              err_q, err_d;
`endif

  logic accept_s;

  // rx_ready_q is the registered ready for the current state, so this is the
  // exact handshake the host sees.
  assign accept_s = bus.rx_valid & rx_ready_q;

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    rcnt_d  = '0;
`ifdef PROG_LOADER_CHKSUM_EN
    chk_d   = chk_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.load_start) begin
          state_d = S_GET_CNT;
          addr_d  = '0;
`ifdef PROG_LOADER_CHKSUM_EN
          chk_d   = 8'd0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      S_GET_CNT: begin
        if (accept_s) begin
          // A count byte of zero stands for a full 256-word image.
          cnt_d   = (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
          idx_d   = 2'd0;
          state_d = S_GET_BYTE;
        end else begin
          state_d = S_GET_CNT;
        end
      end

      S_GET_BYTE: begin
        if (accept_s) begin
`ifdef PROG_LOADER_CHKSUM_EN
          chk_d = chk_q ^ bus.rx_data;
`endif
          if (idx_q == 2'd3) begin
            // Fourth byte completes the word; it is presented in WRITE.
            data_d  = {shift_q, bus.rx_data};
            idx_d   = 2'd0;
            state_d = S_WRITE;
          end else begin
            shift_d = {shift_q[15:0], bus.rx_data};
            idx_d   = idx_q + 2'd1;
          end
        end else begin
          state_d = S_GET_BYTE;
        end
      end

      S_WRITE: begin
        addr_d = addr_q + ADDR_W'(1'b1);
        cnt_d  = cnt_q - 9'd1;
        if (cnt_q == 9'd1) begin
`ifdef PROG_LOADER_CHKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_RST_CPU;
`endif
        end else begin
          state_d = S_GET_BYTE;
        end
      end

`ifdef PROG_LOADER_CHKSUM_EN
      S_CHK: begin
        if (accept_s) begin
          if (bus.rx_data == chk_q) begin
            state_d = S_RST_CPU;
          end else begin
            state_d = S_ERR;
          end
        end else begin
          state_d = S_CHK;
        end
      end

      S_ERR: begin
        if (bus.load_start) begin
          state_d = S_GET_CNT;
          addr_d  = '0;
          chk_d   = 8'd0;
        end else begin
          state_d = S_ERR;
        end
      end
`endif

      S_RST_CPU: begin
        if (rcnt_q == RC_LAST) begin
          state_d = S_RUN;
        end else begin
          rcnt_d  = rcnt_q + RC_W'(1'b1);
          state_d = S_RST_CPU;
        end
      end

      S_RUN: begin
        if (bus.load_start) begin
          state_d = S_GET_CNT;
          addr_d  = '0;
`ifdef PROG_LOADER_CHKSUM_EN
          chk_d   = 8'd0;
`endif
        end else begin
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode of the state being entered; loaded into the output flops.
  always_comb begin
    we_d        = 1'b0;
    rx_ready_d  = 1'b0;
    prog_mode_d = 1'b0;
    cpu_reset_d = 1'b1;
    busy_d      = 1'b0;
    done_d      = 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
    err_d       = 1'b0;
`endif

    case (state_d)
      S_IDLE: begin
        prog_mode_d = 1'b0;
        cpu_reset_d = 1'b1;
      end
      S_GET_CNT, S_GET_BYTE: begin
        rx_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
      S_WRITE: begin
        we_d   = 1'b1;
        busy_d = 1'b1;
      end
`ifdef PROG_LOADER_CHKSUM_EN
      S_CHK: begin
        rx_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
      S_ERR: begin
        err_d = 1'b1;
      end
`endif
      S_RST_CPU: begin
        prog_mode_d = 1'b1;
        cpu_reset_d = 1'b1;
        busy_d      = 1'b1;
      end
      S_RUN: begin
        prog_mode_d = 1'b1;
        cpu_reset_d = 1'b0;
        done_d      = 1'b1;
      end
      default: begin
        prog_mode_d = 1'b0;
        cpu_reset_d = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= 9'd0;
      idx_q       <= 2'd0;
      shift_q     <= 24'd0;
      data_q      <= 32'd0;
      rcnt_q      <= '0;
      we_q        <= 1'b0;
      rx_ready_q  <= 1'b0;
      prog_mode_q <= 1'b0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
      chk_q       <= 8'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      rcnt_q      <= rcnt_d;
      we_q        <= we_d;
      rx_ready_q  <= rx_ready_d;
      prog_mode_q <= prog_mode_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef PROG_LOADER_CHKSUM_EN
      chk_q       <= chk_d;
      err_q       <= err_d;
`endif
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.ProgMode  = prog_mode_q;
  assign bus.Addr_Prog = addr_q;
  assign bus.Data_Prog = data_q;
  assign bus.Prog_We   = we_q;
  assign bus.cpu_reset = cpu_reset_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
`ifdef PROG_LOADER_CHKSUM_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//   Scoreboard bench for prog_loader. Each load builds its byte stream from a
//   list of words; the expected memory writes (address = word index mod 256,
//   data = word) are queued before the stream is sent, and a monitor pops and
//   compares them whenever Prog_We is seen.
// -----------------------------------------------------------------------------
module tb_prog_loader;
  localparam int ADDR_W     = 8;
  localparam int RST_CYCLES = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  prog_loader #(.ADDR_W(ADDR_W), .RST_CYCLES(RST_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  logic [31:0] word_buf [256];
  logic        prev_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe is compared against the next expected write.
  always begin : monitor
    wr_t e;
    @(posedge clk);
    #1;
    if (bus.Prog_We === 1'b1) begin
      check("we_single_cycle", {31'd0, prev_we}, 32'd0);
      check("rx_ready_in_write", {31'd0, bus.rx_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %h data %h, no write expected", bus.Addr_Prog, bus.Data_Prog);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", {{(32-ADDR_W){1'b0}}, bus.Addr_Prog}, {{(32-ADDR_W){1'b0}}, e.addr});
        check("write_data", bus.Data_Prog, e.data);
      end
    end
    prev_we = bus.Prog_We;
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (bus.rx_ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
      end
    end
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: byte %h never accepted, rx_ready stayed %b", b, bus.rx_ready);
    end
  endtask

  task automatic pulse_load_start();
    bus.load_start = 1'b1;
    @(posedge clk);
    #1;
    bus.load_start = 1'b0;
  endtask

  // cnt_byte: header; abort_after: bytes to send before stopping (-1 = whole
  // stream); gap_mode: 0 none, 1 alternate cycles, 2 random; ls_at: byte index
  // before which load_start is pulsed (-1 = never); bad_chk: corrupt checksum.
  task automatic run_load(input logic [7:0] cnt_byte, input int abort_after,
                          input int gap_mode, input int ls_at, input bit bad_chk);
    int         nw;
    int         n_exp;
    int         rc;
    bit         fin;
    bit         expect_err;
    logic [7:0] bytes[$];
    logic [7:0] x;
    logic [7:0] bv;
    wr_t        w;

    nw = (cnt_byte == 8'd0) ? 256 : int'(cnt_byte);
    x  = 8'd0;
    bytes.push_back(cnt_byte);
    for (int i = 0; i < nw; i++) begin
      for (int b = 0; b < 4; b++) begin
        bv = word_buf[i][31 - 8*b -: 8];
        bytes.push_back(bv);
        x = x ^ bv;
      end
    end
`ifdef PROG_LOADER_CHKSUM_EN
    bytes.push_back(bad_chk ? (x ^ 8'h5A) : x);
    expect_err = bad_chk;
`else
    expect_err = 1'b0;
`endif

    n_exp = (abort_after < 0) ? nw : (abort_after - 1) / 4;
    for (int i = 0; i < n_exp; i++) begin
      w.addr = ADDR_W'(i);
      w.data = word_buf[i];
      exp_q.push_back(w);
    end

    pulse_load_start();
    check("start_busy", {31'd0, bus.busy}, 32'd1);
    check("start_progmode", {31'd0, bus.ProgMode}, 32'd0);
    check("start_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
    check("start_addr", {{(32-ADDR_W){1'b0}}, bus.Addr_Prog}, 32'd0);
    check("start_done", {31'd0, bus.done}, 32'd0);

    for (int k = 0; k < bytes.size(); k++) begin
      if (abort_after >= 0 && k == abort_after) return;
      if (k == ls_at) pulse_load_start();
      if (gap_mode == 1) begin
        @(posedge clk);
        #1;
      end else if (gap_mode == 2) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      if (gap_mode != 0 && k == 5) begin
        repeat (10) begin
          @(posedge clk);
          #1;
        end
      end
      send_byte(bytes[k]);
    end

    rc  = 0;
    fin = 1'b0;
    for (int c = 0; c < 60 && !fin; c++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1 || bus.err === 1'b1) fin = 1'b1;
      else if (bus.ProgMode === 1'b1 && bus.cpu_reset === 1'b1) rc++;
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL load_end_timeout: done %b err %b after 60 cycles", bus.done, bus.err);
    end
    check("end_done", {31'd0, bus.done}, {31'd0, ~expect_err});
    check("end_err", {31'd0, bus.err}, {31'd0, expect_err});
    check("end_progmode", {31'd0, bus.ProgMode}, {31'd0, ~expect_err});
    check("end_cpu_reset", {31'd0, bus.cpu_reset}, {31'd0, expect_err});
    check("end_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_pulse_cycles", rc, expect_err ? 32'd0 : RST_CYCLES);
    check("end_addr", {{(32-ADDR_W){1'b0}}, bus.Addr_Prog}, nw % 256);
    check("writes_outstanding", exp_q.size(), 32'd0);
  endtask

  task automatic set_basic_words();
    word_buf[0] = 32'h10200007;
    word_buf[1] = 32'h10400008;
    word_buf[2] = 32'h34220001;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int nw;
    bus.load_start = 1'b0;
    bus.rx_valid   = 1'b0;
    bus.rx_data    = 8'd0;
    reset          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_progmode", {31'd0, bus.ProgMode}, 32'd0);
    check("rst_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
    check("rst_addr", {{(32-ADDR_W){1'b0}}, bus.Addr_Prog}, 32'd0);
    check("rst_data", bus.Data_Prog, 32'd0);
    check("rst_we", {31'd0, bus.Prog_We}, 32'd0);
    check("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    check("rst_status", {29'd0, bus.busy, bus.done, bus.err}, 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
    check("idle_rx_ready", {31'd0, bus.rx_ready}, 32'd0);

    // Basic load, then the same image with backpressure.
    set_basic_words();
    run_load(8'd3, -1, 0, -1, 1'b0);
    run_load(8'd3, -1, 1, -1, 1'b0);

    // load_start while busy receiving words is ignored.
    run_load(8'd3, -1, 0, 6, 1'b0);

    // Full 256-word image, address wraps back to 0.
    for (int i = 0; i < 256; i++) word_buf[i] = i;
    run_load(8'd0, -1, 0, -1, 1'b0);

    // Random images with random gaps.
    for (int r = 0; r < 5; r++) begin
      nw = $urandom_range(1, 20);
      for (int i = 0; i < nw; i++) word_buf[i] = $urandom;
      run_load(8'(nw), -1, 2, (r == 0) ? 9 : -1, 1'b0);
    end

    // Reset after byte 2 of word 1, then a fresh load from address 0.
    set_basic_words();
    run_load(8'd3, 7, 0, -1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("abort_progmode", {31'd0, bus.ProgMode}, 32'd0);
    check("abort_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_addr", {{(32-ADDR_W){1'b0}}, bus.Addr_Prog}, 32'd0);
    check("abort_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_writes_outstanding", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
    run_load(8'd3, -1, 0, -1, 1'b0);

`ifdef PROG_LOADER_CHKSUM_EN
    // Wrong checksum parks in ERR; a correct reload recovers.
    run_load(8'd3, -1, 0, -1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("err_held", {29'd0, bus.err, bus.cpu_reset, bus.ProgMode}, 32'd6);
    run_load(8'd3, -1, 1, -1, 1'b0);
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
